// File: rtl/rom_loader_mc.sv
// ============================================================================
// Module      : rom_loader_mc
// Description : ioctl ROM stream parser; routes regions to a packed SDRAM
//               writer (linear / reorder16) or one-hot BRAM chip-selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_loader_mc #(
    parameter int                                NUM_REGIONS = 16,
    parameter int                                SDR_DW      = 16,
    parameter int                                BRAM_CS_W   = 6,
    parameter int                                BRAM_AW     = 20,
    parameter logic [NUM_REGIONS*25-1:0]         REGION_BASE = '0,
    parameter logic [NUM_REGIONS*BRAM_CS_W-1:0]  REGION_CS   = '0,
    parameter logic [NUM_REGIONS*2-1:0]          REGION_MODE = '0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   ioctl_downl,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_data,
    output logic                   ioctl_wait,
    output logic [24:0]            sdr_addr,
    output logic [SDR_DW-1:0]      sdr_data,
    output logic [SDR_DW/8-1:0]    sdr_be,
    output logic                   sdr_req,
    input  logic                   sdr_ack,
    output logic [BRAM_AW-1:0]     bram_addr,
    output logic [7:0]             bram_data,
    output logic [BRAM_CS_W-1:0]   bram_cs,
    output logic                   bram_wr,
    output logic [7:0]             board_cfg,
    output logic                   load_err,
    output logic                   load_done
);

    localparam int         c_NB   = SDR_DW / 8;
    localparam int         c_LW   = $clog2(c_NB);
    localparam logic [7:0] c_NREG = 8'(NUM_REGIONS);

    localparam logic [3:0] c_S_BOARD_CFG = 4'd0;
    localparam logic [3:0] c_S_REGION_IDX = 4'd1;
    localparam logic [3:0] c_S_SIZE_0    = 4'd2;
    localparam logic [3:0] c_S_SIZE_1    = 4'd3;
    localparam logic [3:0] c_S_SIZE_2    = 4'd4;
    localparam logic [3:0] c_S_SDR_DATA  = 4'd5;
    localparam logic [3:0] c_S_BRAM_DATA = 4'd6;
    localparam logic [3:0] c_S_SKIP      = 4'd7;
    localparam logic [3:0] c_S_SDR_FLUSH = 4'd8;

    logic [3:0]            r_state, w_state_next;
    logic                  r_wr_d, r_downl_d, w_byte;
    logic [3:0]            r_region, w_reg_inc, w_idx_next, w_tbl;
    logic                  r_bad, w_idx_bad;
    logic [23:0]           r_size, w_size_full;
    logic [24:0]           r_offset, r_base;
    logic [1:0]            r_mode;
    logic                  w_last;
    logic [24:0]           w_tbl_base;
    logic [BRAM_CS_W-1:0]  w_tbl_cs;
    logic [1:0]            w_tbl_mode;

    logic [SDR_DW-1:0]     r_acc_data, w_lin_data;
    logic [c_NB-1:0]       r_acc_be, w_lin_be, w_ro_be;
    logic [24:0]           r_acc_addr, w_word_addr, w_ro_addr;
    logic [c_LW-1:0]       w_lane;
    logic                  w_lane_full;

    logic                  r_pend_valid;
    logic [24:0]           r_pend_addr;
    logic [SDR_DW-1:0]     r_pend_data;
    logic [c_NB-1:0]       r_pend_be;
    logic                  w_push, w_load_pend, w_load_push, w_pend_free;
    logic [24:0]           w_push_addr;
    logic [SDR_DW-1:0]     w_push_data;
    logic [c_NB-1:0]       w_push_be;
    logic                  r_done_armed;

    assign w_byte      = ioctl_downl & ioctl_wr & ~r_wr_d;
    assign w_reg_inc   = r_region + 4'd1;
    assign w_idx_next  = (ioctl_data == 8'hFF) ? w_reg_inc : ioctl_data[3:0];
    assign w_idx_bad   = (ioctl_data == 8'hFF) ? ({4'd0, w_reg_inc} >= c_NREG)
                                               : (ioctl_data >= c_NREG);
    assign w_tbl       = r_bad ? 4'd0 : r_region;
    assign w_tbl_base  = REGION_BASE[int'(w_tbl)*25 +: 25];
    assign w_tbl_cs    = REGION_CS[int'(w_tbl)*BRAM_CS_W +: BRAM_CS_W];
    assign w_tbl_mode  = REGION_MODE[int'(w_tbl)*2 +: 2];
    // Size field is little-endian: SIZE_0 carries bits [7:0].
    assign w_size_full = {ioctl_data, r_size[15:0]};
    assign w_last      = (r_offset == {1'b0, r_size - 24'd1});
    assign w_lane      = r_offset[c_LW-1:0];
    assign w_lane_full = &w_lane;
    assign w_word_addr = r_base + (r_offset & ~25'(c_NB - 1));
    assign w_ro_addr   = r_base + {r_offset[24:5], r_offset[2:0], r_offset[4:3]};

    always_comb begin
        w_lin_data = r_acc_data;
        w_lin_data[int'(w_lane)*8 +: 8] = ioctl_data;
        w_lin_be = r_acc_be;
        w_lin_be[w_lane] = 1'b1;
        w_ro_be = '0;
        w_ro_be[w_ro_addr[c_LW-1:0]] = 1'b1;
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= c_S_BOARD_CFG;
        else            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!ioctl_downl) begin
            w_state_next = c_S_BOARD_CFG;
        end else begin
            case (r_state)
                c_S_BOARD_CFG:  if (w_byte) w_state_next = c_S_REGION_IDX;
                c_S_REGION_IDX: if (w_byte) w_state_next = c_S_SIZE_0;
                c_S_SIZE_0:     if (w_byte) w_state_next = c_S_SIZE_1;
                c_S_SIZE_1:     if (w_byte) w_state_next = c_S_SIZE_2;
                c_S_SIZE_2: if (w_byte) begin
                    if (w_size_full == 24'd0)        w_state_next = c_S_REGION_IDX;
                    else if (r_bad || w_tbl_mode[1]) w_state_next = c_S_SKIP;
                    else if (w_tbl_cs != '0)         w_state_next = c_S_BRAM_DATA;
                    else                             w_state_next = c_S_SDR_DATA;
                end
                c_S_SDR_DATA: if (w_byte && w_last) begin
                    if (r_mode == 2'd0 && !w_lane_full) w_state_next = c_S_SDR_FLUSH;
                    else                                w_state_next = c_S_REGION_IDX;
                end
                c_S_BRAM_DATA, c_S_SKIP: if (w_byte && w_last) w_state_next = c_S_REGION_IDX;
                c_S_SDR_FLUSH: if (w_pend_free) w_state_next = c_S_REGION_IDX;
                default: w_state_next = c_S_BOARD_CFG;
            endcase
        end
    end

    // Output / word-push logic
    always_comb begin
        w_push      = 1'b0;
        w_push_addr = w_word_addr;
        w_push_data = w_lin_data;
        w_push_be   = '1;
        w_load_pend = !sdr_req && r_pend_valid;
        w_pend_free = !r_pend_valid || w_load_pend;
        if (r_state == c_S_SDR_DATA && w_byte) begin
            if (r_mode == 2'd1) begin
                w_push      = 1'b1;
                w_push_addr = w_ro_addr;
                w_push_data = {c_NB{ioctl_data}};
                w_push_be   = w_ro_be;
            end else if (w_lane_full) begin
                w_push = 1'b1;
            end
        end else if (r_state == c_S_SDR_FLUSH && ioctl_downl && w_pend_free) begin
            w_push      = 1'b1;
            w_push_addr = r_acc_addr;
            w_push_data = r_acc_data;
            w_push_be   = r_acc_be;
        end
        w_load_push = w_push && !sdr_req && !r_pend_valid;
        ioctl_wait  = r_pend_valid || (r_state == c_S_SDR_FLUSH);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_d     <= 1'b0;
            r_downl_d  <= 1'b0;
            r_region   <= 4'd0;
            r_bad      <= 1'b0;
            r_size     <= '0;
            r_offset   <= '0;
            r_base     <= '0;
            r_mode     <= 2'd0;
            board_cfg  <= 8'd0;
            load_err   <= 1'b0;
            bram_cs    <= '0;
            bram_addr  <= '0;
            bram_data  <= 8'd0;
            bram_wr    <= 1'b0;
            r_acc_data <= '0;
            r_acc_be   <= '0;
            r_acc_addr <= '0;
        end else begin
            r_wr_d    <= ioctl_wr;
            r_downl_d <= ioctl_downl;
            bram_wr   <= 1'b0;
            if (ioctl_downl && !r_downl_d) load_err <= 1'b0;
            else if (r_state == c_S_REGION_IDX && w_byte && w_idx_bad) load_err <= 1'b1;

            if (!ioctl_downl) begin
                r_region <= 4'd0;
                r_bad    <= 1'b0;
            end else if (w_byte) begin
                case (r_state)
                    c_S_BOARD_CFG: board_cfg <= ioctl_data;
                    c_S_REGION_IDX: begin
                        r_region <= w_idx_next;
                        r_bad    <= w_idx_bad;
                    end
                    c_S_SIZE_0: r_size[7:0]  <= ioctl_data;
                    c_S_SIZE_1: r_size[15:8] <= ioctl_data;
                    c_S_SIZE_2: begin
                        r_size[23:16] <= ioctl_data;
                        r_offset      <= '0;
                        r_base        <= w_tbl_base;
                        r_mode        <= r_bad ? 2'd2 : w_tbl_mode;
                        bram_cs       <= r_bad ? '0 : w_tbl_cs;
                    end
                    c_S_BRAM_DATA: begin
                        r_offset  <= r_offset + 25'd1;
                        bram_addr <= r_offset[BRAM_AW-1:0];
                        bram_data <= ioctl_data;
                        bram_wr   <= 1'b1;
                    end
                    c_S_SDR_DATA, c_S_SKIP: r_offset <= r_offset + 25'd1;
                    default: ;
                endcase
            end

            if (!ioctl_downl || (r_state == c_S_SIZE_2 && w_byte) ||
                (r_state == c_S_SDR_FLUSH && w_pend_free)) begin
                r_acc_data <= '0;
                r_acc_be   <= '0;
            end else if (r_state == c_S_SDR_DATA && w_byte && r_mode == 2'd0) begin
                r_acc_data <= w_lane_full ? '0 : w_lin_data;
                r_acc_be   <= w_lane_full ? '0 : w_lin_be;
                r_acc_addr <= w_word_addr;
            end
        end
    end

    // Two-deep write queue: output register plus one pending word
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sdr_req      <= 1'b0;
            sdr_addr     <= '0;
            sdr_data     <= '0;
            sdr_be       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_pend_be    <= '0;
            r_done_armed <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            if (sdr_req && sdr_ack) begin
                sdr_req <= 1'b0;
            end else if (w_load_pend) begin
                sdr_req  <= 1'b1;
                sdr_addr <= r_pend_addr;
                sdr_data <= r_pend_data;
                sdr_be   <= r_pend_be;
            end else if (w_load_push) begin
                sdr_req  <= 1'b1;
                sdr_addr <= w_push_addr;
                sdr_data <= w_push_data;
                sdr_be   <= w_push_be;
            end
            if (w_load_pend) r_pend_valid <= 1'b0;
            if (w_push && !w_load_push) begin
                r_pend_valid <= 1'b1;
                r_pend_addr  <= w_push_addr;
                r_pend_data  <= w_push_data;
                r_pend_be    <= w_push_be;
            end

            load_done <= 1'b0;
            if (ioctl_downl) begin
                r_done_armed <= 1'b0;
            end else if (r_downl_d) begin
                r_done_armed <= 1'b1;
            end else if (r_done_armed && !sdr_req && !r_pend_valid) begin
                r_done_armed <= 1'b0;
                load_done    <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
